// File: rtl/collector_pkg.sv
// Shared types and constants for the verdict collector.
// Latency: n/a (types and a pure combinational helper only).
// Backpressure: n/a.
// Contents: stream count/width constants, snapshot record layout, FSM states, lowest-set-bit helper.
package collector_pkg;

    localparam int NSTREAMS = 6;
    localparam int VW       = 64;
    localparam int TW       = 32;
    localparam int IDW      = 3;

    // One captured cycle: the stamp, which streams fired, and all stream values.
    typedef struct packed {
        logic [TW-1:0]                stamp;
        logic [NSTREAMS-1:0]          mask;
        logic [NSTREAMS-1:0][VW-1:0]  values;
    } snapshot_t;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

    // Index of the lowest set bit; 0 when the mask is empty.
    function automatic logic [IDW-1:0] lowest_set(input logic [NSTREAMS-1:0] m);
        logic [IDW-1:0] idx;
        idx = '0;
        for (int i = NSTREAMS - 1; i >= 0; i--) begin
            if (m[i]) idx = IDW'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/snapshot_fifo.sv
// Snapshot FIFO: DEPTH-entry first-word-fall-through store with a registered occupancy count.
// Latency: a push is visible at the head one cycle later; the head is read combinationally.
// Backpressure: caller pushes only when not full or when popping in the same cycle.
// Ports: clk, rst (async active-low), push_i/push_dat_i, pop_i/pop_dat_o, full_o, empty_o.
module snapshot_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_dat_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;

    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign pop_dat_o = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Pointers wrap naturally because DEPTH is a power of two.
        if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
        count_d = count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: emptiness is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/verdict_collector.sv
// Verdict collector: snapshots active streams each enabled cycle and replays them as per-stream records.
// Latency: activity in cycle N reaches rec_valid in cycle N+2 when idle; back-to-back snapshots emit with no bubble.
// Backpressure: rec_ready=0 holds the current record stable; a full FIFO drops new snapshots and counts them.
// Ports: clk, rst (async active-low), en, stream_value/stream_aktv in; rec_* record out with rec_ready; overflow, drop_count, clear_ovf.
module verdict_collector import collector_pkg::*; #(
    parameter int NSTREAMS = collector_pkg::NSTREAMS,
    parameter int DEPTH    = 4,
    parameter int VW       = collector_pkg::VW,
    parameter int TW       = collector_pkg::TW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [NSTREAMS*VW-1:0] stream_value,
    input  logic [NSTREAMS-1:0]    stream_aktv,
    output logic                   rec_valid,
    input  logic                   rec_ready,
    output logic [IDW-1:0]         rec_id,
    output logic [TW-1:0]          rec_time,
    output logic [VW-1:0]          rec_value,
    output logic                   rec_last,
    output logic                   overflow,
    output logic [15:0]            drop_count,
    input  logic                   clear_ovf
);

    state_e                      state_q, state_d;
    logic [TW-1:0]               ts_q, ts_d;
    logic [NSTREAMS-1:0]         mask_q, mask_d;
    logic [TW-1:0]               stamp_q, stamp_d;
    logic [NSTREAMS-1:0][VW-1:0] values_q, values_d;

    logic                        rec_valid_q, rec_valid_d;
    logic [IDW-1:0]              rec_id_q, rec_id_d;
    logic [TW-1:0]               rec_time_q, rec_time_d;
    logic [VW-1:0]               rec_value_q, rec_value_d;
    logic                        rec_last_q, rec_last_d;
    logic                        ovf_q, ovf_d;
    logic [15:0]                 drop_q, drop_d;

    snapshot_t push_snap, head_snap;
    logic      fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic      push_req, drop;

    assign push_snap.stamp  = ts_q;
    assign push_snap.mask   = stream_aktv;
    assign push_snap.values = stream_value;

    assign push_req  = en && (stream_aktv != '0);
    // A full FIFO still takes the push if the head leaves on the same edge.
    assign fifo_push = push_req && (!fifo_full || fifo_pop);
    assign drop      = push_req && !fifo_push;
    assign ts_d      = en ? ts_q + TW'(1) : ts_q;

    snapshot_fifo #(
        .WIDTH ($bits(snapshot_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (fifo_push),
        .push_dat_i (push_snap),
        .pop_i      (fifo_pop),
        .pop_dat_o  (head_snap),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        stamp_d  = stamp_q;
        values_d = values_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    mask_d   = head_snap.mask;
                    stamp_d  = head_snap.stamp;
                    values_d = head_snap.values;
                    state_d  = EMIT;
                end
            end
            EMIT: begin
                if (rec_ready) begin
                    if (rec_last_q) begin
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            mask_d   = head_snap.mask;
                            stamp_d  = head_snap.stamp;
                            values_d = head_snap.values;
                        end else begin
                            mask_d  = '0;
                            state_d = IDLE;
                        end
                    end else begin
                        // Retire the stream just emitted (always the lowest set bit).
                        mask_d = mask_q & (mask_q - NSTREAMS'(1));
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Record outputs are registered from next-state so they track the FSM with no extra cycle.
        rec_valid_d = (state_d == EMIT);
        rec_id_d    = rec_id_q;
        rec_time_d  = rec_time_q;
        rec_value_d = rec_value_q;
        rec_last_d  = 1'b0;
        if (state_d == EMIT) begin
            rec_id_d    = lowest_set(mask_d);
            rec_value_d = values_d[rec_id_d];
            rec_time_d  = stamp_d;
            rec_last_d  = ((mask_d & (mask_d - NSTREAMS'(1))) == '0);
        end

        // A drop coinciding with a clear is still reported.
        ovf_d  = ovf_q;
        drop_d = drop_q;
        if (clear_ovf) begin
            ovf_d  = drop;
            drop_d = drop ? 16'd1 : 16'd0;
        end else if (drop) begin
            ovf_d  = 1'b1;
            drop_d = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts_q        <= '0;
            mask_q      <= '0;
            stamp_q     <= '0;
            values_q    <= '0;
            rec_valid_q <= 1'b0;
            rec_id_q    <= '0;
            rec_time_q  <= '0;
            rec_value_q <= '0;
            rec_last_q  <= 1'b0;
            ovf_q       <= 1'b0;
            drop_q      <= '0;
        end else begin
            ts_q        <= ts_d;
            mask_q      <= mask_d;
            stamp_q     <= stamp_d;
            values_q    <= values_d;
            rec_valid_q <= rec_valid_d;
            rec_id_q    <= rec_id_d;
            rec_time_q  <= rec_time_d;
            rec_value_q <= rec_value_d;
            rec_last_q  <= rec_last_d;
            ovf_q       <= ovf_d;
            drop_q      <= drop_d;
        end
    end

    assign rec_valid  = rec_valid_q;
    assign rec_id     = rec_id_q;
    assign rec_time   = rec_time_q;
    assign rec_value  = rec_value_q;
    assign rec_last   = rec_last_q;
    assign overflow   = ovf_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_verdict_collector.sv
// Testbench for verdict_collector: directed snapshots, scoreboard of expected records, directed status checks.
// Latency: checks record timing cycle-by-cycle around the capture edge.
// Backpressure: exercises rec_ready stalls and FIFO overflow.
module tb_verdict_collector;

    localparam int NS = 6;
    localparam int VW = 64;
    localparam int TW = 32;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 en = 1'b0;
    logic [NS*VW-1:0]     stream_value = '0;
    logic [NS-1:0]        stream_aktv = '0;
    logic                 rec_ready = 1'b0;
    logic                 clear_ovf = 1'b0;
    logic                 rec_valid;
    logic [2:0]           rec_id;
    logic [TW-1:0]        rec_time;
    logic [VW-1:0]        rec_value;
    logic                 rec_last;
    logic                 overflow;
    logic [15:0]          drop_count;

    verdict_collector #(.NSTREAMS(NS), .DEPTH(4), .VW(VW), .TW(TW)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .stream_value (stream_value),
        .stream_aktv  (stream_aktv),
        .rec_valid    (rec_valid),
        .rec_ready    (rec_ready),
        .rec_id       (rec_id),
        .rec_time     (rec_time),
        .rec_value    (rec_value),
        .rec_last     (rec_last),
        .overflow     (overflow),
        .drop_count   (drop_count),
        .clear_ovf    (clear_ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]    id;
        logic [TW-1:0] t;
        logic [VW-1:0] v;
        logic          last;
    } rec_t;

    rec_t          exp_q[$];
    rec_t          m_exp;
    int            total = 0;
    int            bad = 0;
    int            rec_seen = 0;
    logic [TW-1:0] ts_m;

    // Reference cycle stamp: counts enabled cycles since reset release.
    always @(posedge clk or negedge rst) begin
        if (!rst) ts_m <= '0;
        else if (en) ts_m <= ts_m + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every accepted record must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst && rec_valid && rec_ready) begin
            rec_seen++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: got id=%0d value=%0h expected no record", rec_id, rec_value);
            end else begin
                m_exp = exp_q.pop_front();
                check("sb_id", 64'(rec_id), 64'(m_exp.id));
                check("sb_time", 64'(rec_time), 64'(m_exp.t));
                check("sb_value", rec_value, m_exp.v);
                check("sb_last", 64'(rec_last), 64'(m_exp.last));
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NS*VW-1:0] one_val(input int slot, input logic [VW-1:0] v);
        logic [NS*VW-1:0] r;
        r = '0;
        r[slot*VW +: VW] = v;
        return r;
    endfunction

    // Present one snapshot for one cycle; if it should be kept, queue its records lowest stream first.
    task automatic snap(input logic [NS-1:0] m, input logic [NS*VW-1:0] vals, input bit keep);
        logic [NS-1:0] rem;
        rec_t          r;
        stream_aktv  = m;
        stream_value = vals;
        if (keep) begin
            rem = m;
            for (int i = 0; i < NS; i++) begin
                if (m[i]) begin
                    rem[i] = 1'b0;
                    r.id   = 3'(i);
                    r.t    = ts_m;
                    r.v    = vals[i*VW +: VW];
                    r.last = (rem == '0);
                    exp_q.push_back(r);
                end
            end
        end
        tick();
        stream_aktv = '0;
    endtask

    initial begin
        int            s0;
        logic [TW-1:0] t0;

        // Reset state
        #1 rst = 1'b0;
        #1;
        check("rst_valid", 64'(rec_valid), 64'd0);
        check("rst_id", 64'(rec_id), 64'd0);
        check("rst_time", 64'(rec_time), 64'd0);
        check("rst_value", rec_value, 64'd0);
        check("rst_last", 64'(rec_last), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_drop", 64'(drop_count), 64'd0);
        tick();
        tick();
        rst       = 1'b1;
        en        = 1'b1;
        rec_ready = 1'b1;

        // Single record at stamp 5, visible two cycles later
        repeat (5) tick();
        snap(6'b000001, one_val(0, 64'd1), 1'b1);
        @(negedge clk);
        check("lat_n1_valid", 64'(rec_valid), 64'd0);
        tick();
        @(negedge clk);
        check("lat_valid", 64'(rec_valid), 64'd1);
        check("lat_id", 64'(rec_id), 64'd0);
        check("lat_time", 64'(rec_time), 64'd5);
        check("lat_value", rec_value, 64'd1);
        check("lat_last", 64'(rec_last), 64'd1);
        tick();
        @(negedge clk);
        check("idle_valid", 64'(rec_valid), 64'd0);
        check("idle_last", 64'(rec_last), 64'd0);
        check("idle_time_hold", 64'(rec_time), 64'd5);
        check("idle_value_hold", rec_value, 64'd1);

        // Multi-stream snapshot emits ids 1,3,5 back to back
        snap(6'b101010, one_val(1, 64'd2) | one_val(3, 64'd4) | one_val(5, 64'd6), 1'b1);
        @(negedge clk);
        check("multi_gap", 64'(rec_valid), 64'd0);
        tick();
        @(negedge clk);
        check("multi_id1", 64'(rec_id), 64'd1);
        check("multi_last1", 64'(rec_last), 64'd0);
        tick();
        @(negedge clk);
        check("multi_id3", 64'(rec_id), 64'd3);
        check("multi_valid3", 64'(rec_valid), 64'd1);
        tick();
        @(negedge clk);
        check("multi_id5", 64'(rec_id), 64'd5);
        check("multi_last5", 64'(rec_last), 64'd1);
        tick();
        @(negedge clk);
        check("multi_done", 64'(rec_valid), 64'd0);

        // Stall: record held stable for 5 cycles, then advances
        tick();
        rec_ready = 1'b0;
        t0 = ts_m;
        snap(6'b010100, one_val(2, 64'h33) | one_val(4, 64'h55), 1'b1);
        tick();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_valid", 64'(rec_valid), 64'd1);
            check("stall_id", 64'(rec_id), 64'd2);
            check("stall_time", 64'(rec_time), 64'(t0));
            check("stall_value", rec_value, 64'h33);
            check("stall_last", 64'(rec_last), 64'd0);
            tick();
        end
        rec_ready = 1'b1;
        @(negedge clk);
        check("stall_release_id", 64'(rec_id), 64'd2);
        tick();
        @(negedge clk);
        check("stall_adv_id", 64'(rec_id), 64'd4);
        check("stall_adv_last", 64'(rec_last), 64'd1);
        tick();

        // Overflow: six snapshots while stalled, sixth dropped
        rec_ready = 1'b0;
        for (int v = 1; v <= 6; v++) begin
            snap(6'(1 << (v - 1)), one_val(v - 1, 64'(v)), (v <= 5));
        end
        @(negedge clk);
        check("ovf_flag", 64'(overflow), 64'd1);
        check("ovf_count", 64'(drop_count), 64'd1);
        check("ovf_head_value", rec_value, 64'd1);
        s0 = rec_seen;
        rec_ready = 1'b1;
        repeat (10) tick();
        check("ovf_drain_count", 64'(rec_seen - s0), 64'd5);

        // Clear coinciding with a drop
        rec_ready = 1'b0;
        for (int v = 1; v <= 7; v++) begin
            snap(6'(1 << ((v - 1) % 6)), one_val((v - 1) % 6, 64'h100 + 64'(v)), (v <= 5));
        end
        @(negedge clk);
        check("pre_clr_ovf", 64'(overflow), 64'd1);
        check("pre_clr_count", 64'(drop_count), 64'd3);
        clear_ovf = 1'b1;
        snap(6'b000001, one_val(0, 64'h200), 1'b0);
        clear_ovf = 1'b0;
        @(negedge clk);
        check("clr_drop_ovf", 64'(overflow), 64'd1);
        check("clr_drop_count", 64'(drop_count), 64'd1);
        s0 = rec_seen;
        rec_ready = 1'b1;
        repeat (10) tick();
        check("clr_drain_count", 64'(rec_seen - s0), 64'd5);

        // en=0 blocks capture; counter holds
        en = 1'b0;
        s0 = rec_seen;
        snap(6'b000010, one_val(1, 64'h77), 1'b0);
        repeat (3) tick();
        check("en0_no_record", 64'(rec_seen - s0), 64'd0);
        check("en0_ts_model_hold", 64'(rec_valid), 64'd0);
        en = 1'b1;
        snap(6'b000010, one_val(1, 64'h78), 1'b1);
        repeat (4) tick();
        check("en1_record", 64'(rec_seen - s0), 64'd1);

        // Reset during EMIT with two snapshots queued
        rec_ready = 1'b0;
        snap(6'b000001, one_val(0, 64'hA1), 1'b1);
        snap(6'b000010, one_val(1, 64'hA2), 1'b1);
        snap(6'b000100, one_val(2, 64'hA3), 1'b1);
        @(negedge clk);
        check("pre_rst_valid", 64'(rec_valid), 64'd1);
        check("pre_rst_drop", 64'(drop_count), 64'd1);
        #2 rst = 1'b0;
        #1;
        exp_q.delete();
        check("arst_valid", 64'(rec_valid), 64'd0);
        check("arst_id", 64'(rec_id), 64'd0);
        check("arst_time", 64'(rec_time), 64'd0);
        check("arst_value", rec_value, 64'd0);
        check("arst_last", 64'(rec_last), 64'd0);
        check("arst_ovf", 64'(overflow), 64'd0);
        check("arst_drop", 64'(drop_count), 64'd0);
        tick();
        tick();
        rst       = 1'b1;
        rec_ready = 1'b1;
        s0 = rec_seen;
        repeat (8) tick();
        @(negedge clk);
        check("post_rst_no_rec", 64'(rec_seen - s0), 64'd0);
        check("post_rst_valid", 64'(rec_valid), 64'd0);
        check("post_rst_drop", 64'(drop_count), 64'd0);
        tick();
        snap(6'b000100, one_val(2, 64'hBEEF), 1'b1);
        repeat (4) tick();
        check("post_rst_new_rec", 64'(rec_seen - s0), 64'd1);

        check("sb_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
